// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-clock data-memory controller for the CPU load/store path.
// Handles b/h/w loads and stores with sign/zero extension over byte lanes,
// reports illegal memops, and optionally performs word-boundary-crossing accesses.
// Optional feature macro: DMEM_MISALIGN_EN (defined = split accesses use a second
// memory cycle on word A+1; undefined = split accesses return resp_err=1).
`timescale 1ns/1ps
module dmem_ctrl #(
    parameter int    ADDR_W    = 32,
    parameter int    WORD_AW   = 15,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int DEPTH = 2 ** WORD_AW;

`ifdef DMEM_MISALIGN_EN
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC0, RESP} state_t;
`endif

    state_t             state_reg;
    logic               we_reg;
    logic [2:0]         memop_reg;
    logic [WORD_AW-1:0] word_reg;
    logic [1:0]         off_reg;
    logic [31:0]        wdata_reg;
    logic               err_reg;
    logic [31:0]        rd_data_reg;
`ifdef DMEM_MISALIGN_EN
    logic               split_reg;
    logic [31:0]        lo_reg;
`endif

    // Upper address bits only select aliases of the same word (wrap modulo depth)
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[ADDR_W-1:WORD_AW+2];

    logic [3:0][7:0]    mem [0:DEPTH-1];

    // Request decode on the incoming request
    logic req_illegal, req_split;
    assign req_illegal = (req_memop == 3'b011) || (req_memop == 3'b110) || (req_memop == 3'b111);
    assign req_split   = ((req_memop[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                         ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    assign req_ready = (state_reg == IDLE) && !rst;

    // Lane mask and store data laid out across {A+1, A}
    logic [3:0]  base_mask;
    logic [7:0]  lane_mask;
    logic [63:0] wdata_shift;
    always_comb begin
        base_mask = 4'b0001;
        if (memop_reg[1:0] == 2'b01) base_mask = 4'b0011;
        if (memop_reg[1:0] == 2'b10) base_mask = 4'b1111;
    end
    assign lane_mask   = {4'b0000, base_mask} << off_reg;
    assign wdata_shift = {32'h0, wdata_reg} << {off_reg, 3'b000};

    // Memory port: ACC0 touches word A, ACC1 touches word A+1
    logic [WORD_AW-1:0] mem_addr;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    always_comb begin
        mem_addr  = word_reg;
        mem_be    = 4'b0000;
        mem_wdata = wdata_shift[31:0];
        if (state_reg == ACC0 && we_reg && !err_reg && !rst)
            mem_be = lane_mask[3:0];
`ifdef DMEM_MISALIGN_EN
        if (state_reg == ACC1) begin
            mem_addr  = word_reg + 1'b1;
            mem_wdata = wdata_shift[63:32];
            if (we_reg && !rst)
                mem_be = lane_mask[7:4];
        end
`endif
    end

    // Byte-enable write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_be[i])
                mem[mem_addr][i] <= mem_wdata[8*i +: 8];
        rd_data_reg <= mem[mem_addr];
    end

    // Load assembly: {A+1, A} shifted right by the byte offset
    logic [31:0] load_lo, load_hi;
`ifdef DMEM_MISALIGN_EN
    assign load_lo = split_reg ? lo_reg : rd_data_reg;
    assign load_hi = split_reg ? rd_data_reg : 32'h0;
`else
    assign load_lo = rd_data_reg;
    assign load_hi = 32'h0;
`endif
    logic [63:0] load_pair;
    logic [31:0] load_aligned;
    assign load_pair    = {load_hi, load_lo} >> {off_reg, 3'b000};
    assign load_aligned = load_pair[31:0];

    // Width extension, built lane by lane
    logic [3:0][7:0] load_ext;
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_ext
        always_comb begin
            load_ext[gi] = 8'h00;
            case (memop_reg)
                3'b000: load_ext[gi] = (gi == 0) ? load_aligned[7:0]  : {8{load_aligned[7]}};
                3'b001: load_ext[gi] = (gi < 2)  ? load_aligned[8*gi +: 8] : {8{load_aligned[15]}};
                3'b010: load_ext[gi] = load_aligned[8*gi +: 8];
                3'b100: load_ext[gi] = (gi == 0) ? load_aligned[7:0] : 8'h00;
                3'b101: load_ext[gi] = (gi < 2)  ? load_aligned[8*gi +: 8] : 8'h00;
                default: load_ext[gi] = 8'h00;
            endcase
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        memop_reg <= req_memop;
                        word_reg  <= req_addr[WORD_AW+1:2];
                        off_reg   <= req_addr[1:0];
                        wdata_reg <= req_wdata;
`ifdef DMEM_MISALIGN_EN
                        split_reg <= req_split;
                        err_reg   <= req_illegal;
`else
                        err_reg   <= req_illegal || req_split;
`endif
                        state_reg <= ACC0;
                    end
                end
                ACC0: begin
`ifdef DMEM_MISALIGN_EN
                    state_reg <= (split_reg && !err_reg) ? ACC1 : RESP;
`else
                    state_reg <= RESP;
`endif
                end
`ifdef DMEM_MISALIGN_EN
                ACC1: begin
                    lo_reg    <= rd_data_reg;
                    state_reg <= RESP;
                end
`endif
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_reg;
                    resp_rdata <= (we_reg || err_reg) ? 32'h0 : load_ext;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
